// File: rtl/ex_muldiv.sv
// RV32M execute-stage multiply/divide unit: single-cycle multiply, restoring iterative divide.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             accept;
  logic             early;
  logic [WIDTH-1:0] early_res;

  assign accept = (state == S_IDLE) && start && !flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = op[2] && ((src_b == '0) ||
                 (!op[0] && (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1)));
`else
  assign early = 1'b0;
`endif
  // Divide by zero: quotient all-ones, remainder dividend. Overflow: quotient dividend, remainder 0.
  assign early_res = (src_b == '0) ? (op[1] ? src_a : '1) : (op[1] ? '0 : src_a);

  // Multiply: op[1:0] 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
  logic                 a_sgn, b_sgn;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
  assign a_sgn = (op_q != 2'b11);
  assign b_sgn = (op_q == 2'b01);
  assign a_ext = {{WIDTH{a_sgn & a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{b_sgn & b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  // Divide: op[0]=0 signed, op[1]=1 remainder
  logic             div_sgn, last;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0]   sh, diff;
  assign div_sgn = !op_q[0];
  assign a_mag   = (div_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag   = (div_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
  assign sh      = {rem_q, quo_q[WIDTH-1]};
  assign diff    = sh - {1'b0, dvs_q};
  assign last    = (cnt_q == CW'(WIDTH));
  assign quo_fix = (div_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]) && (b_q != '0)) ? -quo_q : quo_q;
  assign rem_fix = (div_sgn && a_q[WIDTH-1]) ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = early ? S_DONE : (op[2] ? S_DIV : S_MUL);
      S_MUL:  state_nxt = S_DONE;
      S_DIV:  if (last) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE:               busy = start && !flush;
      S_MUL, S_DIV, S_FIX:  busy = 1'b1;
      S_DONE:               done = 1'b1;
      default: ;
    endcase
  end

  // First DIV cycle (cnt 0) loads operand magnitudes; cycles 1..WIDTH each retire one quotient bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q  <= op[1:0];
          a_q   <= src_a;
          b_q   <= src_b;
          cnt_q <= '0;
          if (early) result <= early_res;
        end
        S_MUL: if (!flush) result <= (op_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        S_DIV: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '0) begin
            quo_q <= a_mag;
            dvs_q <= b_mag;
            rem_q <= '0;
          end else if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: if (!flush) result <= op_q[1] ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

endmodule
